// File: rtl/alu_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | alu_issue_ctrl : RV32I ALU/branch issue controller (decode, exec, wb)      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid_i,
    input  logic [31:0] instr_i,
    output logic        instr_ready_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [3:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_flag_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        br_valid_o,
    output logic        br_taken_o,
    output logic        illegal_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLTS = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_NE   = 4'd11;
    localparam logic [3:0] OP_LTS  = 4'd12;
    localparam logic [3:0] OP_GES  = 4'd13;
    localparam logic [3:0] OP_LTU  = 4'd14;
    localparam logic [3:0] OP_GEU  = 4'd15;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] instr_q;
    logic [3:0]  alu_op_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic        is_branch_q;
    logic [31:0] wb_data_q;
    logic        wb_valid_q;
    logic        br_valid_q;
    logic        br_taken_q;
    logic        illegal_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] shamt;

    logic [3:0]  op_d;
    logic [31:0] b_d;
    logic        illegal_d;
    logic        branch_d;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign shamt  = {27'd0, instr_q[24:20]};

    // Only base/alt funct7 exist in RV32I; alt is meaningful for SUB and SRA only.
    always_comb begin
        op_d      = OP_ADD;
        b_d       = rs2_data_i;
        illegal_d = 1'b0;
        branch_d  = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                case (funct3)
                    3'b000:  op_d = funct7[5] ? OP_SUB : OP_ADD;
                    3'b001:  op_d = OP_SLL;
                    3'b010:  op_d = OP_SLTS;
                    3'b011:  op_d = OP_SLTU;
                    3'b100:  op_d = OP_XOR;
                    3'b101:  op_d = funct7[5] ? OP_SRA : OP_SRL;
                    3'b110:  op_d = OP_OR;
                    default: op_d = OP_AND;
                endcase
                if (funct7 != F7_BASE &&
                    !(funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    illegal_d = 1'b1;
                end
            end
            OPC_ITYPE: begin
                b_d = imm_i;
                case (funct3)
                    3'b000:  op_d = OP_ADD;
                    3'b001: begin
                        op_d = OP_SLL;
                        b_d  = shamt;
                        if (funct7 != F7_BASE) illegal_d = 1'b1;
                    end
                    3'b010:  op_d = OP_SLTS;
                    3'b011:  op_d = OP_SLTU;
                    3'b100:  op_d = OP_XOR;
                    3'b101: begin
                        op_d = funct7[5] ? OP_SRA : OP_SRL;
                        b_d  = shamt;
                        if (funct7 != F7_BASE && funct7 != F7_ALT) illegal_d = 1'b1;
                    end
                    3'b110:  op_d = OP_OR;
                    default: op_d = OP_AND;
                endcase
            end
            OPC_BRANCH: begin
                branch_d = 1'b1;
                case (funct3)
                    3'b000:  op_d = OP_EQ;
                    3'b001:  op_d = OP_NE;
                    3'b100:  op_d = OP_LTS;
                    3'b101:  op_d = OP_GES;
                    3'b110:  op_d = OP_LTU;
                    3'b111:  op_d = OP_GEU;
                    default: illegal_d = 1'b1;
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            instr_q     <= 32'd0;
            alu_op_q    <= 4'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            is_branch_q <= 1'b0;
            wb_data_q   <= 32'd0;
            wb_valid_q  <= 1'b0;
            br_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            br_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (instr_valid_i) begin
                        instr_q <= instr_i;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (illegal_d) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        alu_op_q    <= op_d;
                        alu_a_q     <= rs1_data_i;
                        alu_b_q     <= b_d;
                        is_branch_q <= branch_d;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wb_data_q  <= alu_result_i;
                    br_taken_q <= alu_flag_i;
                    if (is_branch_q) begin
                        br_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else if (rd == 5'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        wb_valid_q <= 1'b1;
                        state_q    <= S_WB;
                    end
                end
                default: begin
                    if (wb_ready_i) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign instr_ready_o = (state_q == S_IDLE);
    assign rs1_addr_o    = instr_q[19:15];
    assign rs2_addr_o    = instr_q[24:20];
    assign alu_op_o      = alu_op_q;
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_addr_o     = rd;
    assign wb_data_o     = wb_data_q;
    assign br_valid_o    = br_valid_q;
    assign br_taken_o    = br_taken_q & br_valid_q;
    assign illegal_o     = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_alu_issue_ctrl : directed vector bench for alu_issue_ctrl               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_alu_issue_ctrl;

    localparam int K_WB  = 0;
    localparam int K_BR  = 1;
    localparam int K_ILL = 2;
    localparam int K_RD0 = 3;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        int          kind;
        logic [3:0]  exp_op;
        logic [31:0] exp_b;
        logic [31:0] exp_data;
        logic        exp_taken;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        alu_flag;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br_valid;
    logic        br_taken;
    logic        illegal;

    logic [31:0] regs [32];
    int          n_checks = 0;
    int          n_err    = 0;
    int          n_xfer   = 0;

    alu_issue_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_i (instr_valid),
        .instr_i       (instr),
        .instr_ready_o (instr_ready),
        .rs1_addr_o    (rs1_addr),
        .rs2_addr_o    (rs2_addr),
        .rs1_data_i    (rs1_data),
        .rs2_data_i    (rs2_data),
        .alu_op_o      (alu_op),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_result_i  (alu_result),
        .alu_flag_i    (alu_flag),
        .wb_valid_o    (wb_valid),
        .wb_ready_i    (wb_ready),
        .wb_addr_o     (wb_addr),
        .wb_data_o     (wb_data),
        .br_valid_o    (br_valid),
        .br_taken_o    (br_taken),
        .illegal_o     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

    // Reference ALU sitting on the far side of the controller.
    always_comb begin
        alu_result = 32'd0;
        alu_flag   = 1'b0;
        case (alu_op)
            4'd0:  alu_result = alu_a + alu_b;
            4'd1:  alu_result = alu_a - alu_b;
            4'd2:  alu_result = alu_a << alu_b[4:0];
            4'd3:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd4:  alu_result = {31'd0, alu_a < alu_b};
            4'd5:  alu_result = alu_a ^ alu_b;
            4'd6:  alu_result = alu_a >> alu_b[4:0];
            4'd7:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'd8:  alu_result = alu_a | alu_b;
            4'd9:  alu_result = alu_a & alu_b;
            4'd10: alu_flag = (alu_a == alu_b);
            4'd11: alu_flag = (alu_a != alu_b);
            4'd12: alu_flag = ($signed(alu_a) < $signed(alu_b));
            4'd13: alu_flag = ($signed(alu_a) >= $signed(alu_b));
            4'd14: alu_flag = (alu_a < alu_b);
            default: alu_flag = (alu_a >= alu_b);
        endcase
    end

    always @(posedge clk) if (rst_n && wb_valid && wb_ready) n_xfer <= n_xfer + 1;

    function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] b_enc(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {7'd0, rs2, rs1, f3, 5'd0, 7'b1100011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {27'd0, rs1_addr} | {27'd0, rs2_addr} | {28'd0, alu_op} | alu_a | alu_b |
               {31'd0, wb_valid} | {27'd0, wb_addr} | wb_data | {31'd0, br_valid} |
               {31'd0, br_taken} | {31'd0, illegal};
    endfunction

    // Waits for instr_ready (bounded), then performs one handshake; returns in cycle N+1.
    task automatic issue(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("issue_timeout", 32'(n), 32'd0);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic load_regs(input vec_t v);
        regs[v.instr[24:20]] = v.b;
        regs[v.instr[19:15]] = v.a;
    endtask

    // Checks the timeline from cycle N+1; ends at the negedge of N+3 (N+4 for WB).
    task automatic check_flow(input vec_t v);
        @(negedge clk);
        chk("decode_ready", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        if (v.kind == K_ILL) begin
            chk("illegal_pulse", {31'd0, illegal}, 32'd1);
            chk("illegal_ready", {31'd0, instr_ready}, 32'd1);
        end else begin
            chk("exec_op", {28'd0, alu_op}, {28'd0, v.exp_op});
            chk("exec_a", alu_a, v.a);
            chk("exec_b", alu_b, v.exp_b);
        end
        @(negedge clk);
        case (v.kind)
            K_WB: begin
                chk("wb_valid", {31'd0, wb_valid}, 32'd1);
                chk("wb_addr", {27'd0, wb_addr}, {27'd0, v.instr[11:7]});
                chk("wb_data", wb_data, v.exp_data);
                @(negedge clk);
                chk("wb_drop", {31'd0, wb_valid}, 32'd0);
            end
            K_BR: begin
                chk("br_valid", {31'd0, br_valid}, 32'd1);
                chk("br_taken", {31'd0, br_taken}, {31'd0, v.exp_taken});
                chk("br_nowb", {31'd0, wb_valid}, 32'd0);
                chk("br_ready", {31'd0, instr_ready}, 32'd1);
            end
            K_ILL: begin
                chk("ill_quiet", {29'd0, illegal, br_valid, wb_valid}, 32'd0);
            end
            default: begin
                chk("rd0_nowb", {30'd0, br_valid, wb_valid}, 32'd0);
                chk("rd0_ready", {31'd0, instr_ready}, 32'd1);
            end
        endcase
    endtask

    vec_t vecs [17];
    vec_t v1;
    vec_t v2;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'd0;
        wb_ready    = 1'b1;

        vecs[0]  = '{r_enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd6), 32'd5, 32'd7, K_WB, 4'd0, 32'd7, 32'd12, 1'b0};
        vecs[1]  = '{r_enc(7'h00, 5'd2, 5'd1, 3'b011, 5'd7), 32'd1, 32'hFFFFFFFF, K_WB, 4'd4, 32'hFFFFFFFF, 32'd1, 1'b0};
        vecs[2]  = '{r_enc(7'h00, 5'd10, 5'd9, 3'b100, 5'd8), 32'hF0F0F0F0, 32'hFFFF0000, K_WB, 4'd5, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0};
        vecs[3]  = '{r_enc(7'h20, 5'd13, 5'd12, 3'b101, 5'd11), 32'h80000010, 32'd4, K_WB, 4'd7, 32'd4, 32'hF8000001, 1'b0};
        vecs[4]  = '{r_enc(7'h01, 5'd2, 5'd1, 3'b111, 5'd9), 32'd1, 32'd2, K_ILL, 4'd0, 32'd0, 32'd0, 1'b0};
        vecs[5]  = '{i_enc(12'hFFF, 5'd15, 3'b000, 5'd14), 32'd10, 32'd0, K_WB, 4'd0, 32'hFFFFFFFF, 32'd9, 1'b0};
        vecs[6]  = '{i_enc(12'h404, 5'd4, 3'b101, 5'd5), 32'h80000000, 32'd0, K_WB, 4'd7, 32'd4, 32'hF8000000, 1'b0};
        vecs[7]  = '{i_enc(12'h403, 5'd4, 3'b001, 5'd5), 32'd1, 32'd0, K_ILL, 4'd0, 32'd0, 32'd0, 1'b0};
        vecs[8]  = '{i_enc(12'h0F0, 5'd17, 3'b110, 5'd16), 32'h00000F00, 32'd0, K_WB, 4'd8, 32'h000000F0, 32'h00000FF0, 1'b0};
        vecs[9]  = '{i_enc(12'hFFB, 5'd19, 3'b010, 5'd18), 32'hFFFFFFF0, 32'd0, K_WB, 4'd3, 32'hFFFFFFFB, 32'd1, 1'b0};
        vecs[10] = '{b_enc(5'd2, 5'd1, 3'b110), 32'd1, 32'hFFFFFFFF, K_BR, 4'd14, 32'hFFFFFFFF, 32'd0, 1'b1};
        vecs[11] = '{b_enc(5'd2, 5'd1, 3'b000), 32'd3, 32'd4, K_BR, 4'd10, 32'd4, 32'd0, 1'b0};
        vecs[12] = '{b_enc(5'd21, 5'd20, 3'b101), 32'hFFFFFFFF, 32'd1, K_BR, 4'd13, 32'd1, 32'd0, 1'b0};
        vecs[13] = '{b_enc(5'd2, 5'd1, 3'b001), 32'd3, 32'd4, K_BR, 4'd11, 32'd4, 32'd0, 1'b1};
        vecs[14] = '{b_enc(5'd2, 5'd1, 3'b010), 32'd3, 32'd4, K_ILL, 4'd0, 32'd0, 32'd0, 1'b0};
        vecs[15] = '{32'h00A08183, 32'd3, 32'd0, K_ILL, 4'd0, 32'd0, 32'd0, 1'b0};
        vecs[16] = '{i_enc(12'h001, 5'd1, 3'b000, 5'd0), 32'd5, 32'd0, K_RD0, 4'd0, 32'd1, 32'd0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outs", all_outs(), 32'd0);
        chk("reset_ready", {31'd0, instr_ready}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            load_regs(vecs[i]);
            issue(vecs[i].instr);
            check_flow(vecs[i]);
        end

        // SUB with a four-cycle write-back stall.
        v1 = '{r_enc(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, K_WB, 4'd1, 32'd7, 32'hFFFFFFFE, 1'b0};
        load_regs(v1);
        wb_ready = 1'b0;
        n_xfer   = 0;
        issue(v1.instr);
        @(negedge clk);
        @(negedge clk);
        chk("sub_op", {28'd0, alu_op}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_hold", {wb_valid, 26'd0, wb_addr}, {1'b1, 26'd0, 5'd3});
            chk("stall_data", wb_data, 32'hFFFFFFFE);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("stall_drop", {31'd0, wb_valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("stall_xfers", 32'(n_xfer), 32'd1);

        // Back-to-back BEQ: second handshake in the br_valid cycle.
        v1 = '{b_enc(5'd2, 5'd1, 3'b000), 32'd9, 32'd9, K_BR, 4'd10, 32'd9, 32'd0, 1'b1};
        v2 = '{b_enc(5'd4, 5'd3, 3'b000), 32'd1, 32'd2, K_BR, 4'd10, 32'd2, 32'd0, 1'b0};
        load_regs(v1);
        load_regs(v2);
        issue(v1.instr);
        check_flow(v1);
        instr_valid = 1'b1;
        instr       = v2.instr;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        check_flow(v2);

        // Reset during a stalled write-back.
        wb_ready = 1'b0;
        load_regs(vecs[0]);
        issue(vecs[0].instr);
        repeat (3) @(negedge clk);
        chk("prereset_wb", {31'd0, wb_valid}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_xfer   = 0;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("midwb_outs", all_outs(), 32'd0);
        chk("midwb_ready", {31'd0, instr_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midwb_quiet", {29'd0, wb_valid, br_valid, illegal}, 32'd0);
        end
        chk("midwb_xfers", 32'(n_xfer), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits on the driving side of the 32-bit ALU. It accepts one RV32I instruction word per handshake and decodes R-type, I-type ALU and branch formats into the ALU's 4-bit operation code. It fetches operands from the register file, drives the ALU, and captures the result or compare flag. It then hands the result to write-back over a valid/ready handshake, or reports the branch decision.

## Interface
- No parameters. Data width is fixed at 32 bits; the ALU op field is 4 bits.
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction word available
- instr  in  32  RV32I instruction word
- instr_ready  out  1  controller can accept an instruction (IDLE only)
- rs1_addr, rs2_addr  out  5 each  register-file read addresses (instr[19:15], instr[24:20])
- rs1_data, rs2_data  in  32 each  combinational register-file read data
- alu_op  out  4  ALU operation code
- alu_a, alu_b  out  32 each  ALU operands
- alu_result  in  32  ALU result
- alu_flag  in  1  ALU compare flag
- wb_valid  out  1  write-back request
- wb_ready  in  1  write-back accepted
- wb_addr  out  5  destination register (instr[11:7])
- wb_data  out  32  captured ALU result
- br_valid  out  1  one-cycle pulse: branch decision is valid
- br_taken  out  1  captured alu_flag, qualified by br_valid
- illegal  out  1  one-cycle pulse: unsupported instruction

## Operation
- **ALU op codes (fixed):**
  - ADD 0, SUB 1, SLL 2, SLTS 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9
  - EQ 10, NE 11, LTS 12, GES 13, LTU 14, GEU 15
- **Opcode 0110011 (R-type):**
  - funct3 000: funct7 0000000 → ADD, 0100000 → SUB
  - 001 → SLL, 010 → SLTS, 011 → SLTU, 100 → XOR
  - 101: funct7 0000000 → SRL, 0100000 → SRA
  - 110 → OR, 111 → AND
  - Any other funct7 → illegal.
  - alu_b = rs2_data.
- **Opcode 0010011 (I-type):**
  - Same funct3 map, with funct3 000 always ADD.
  - alu_b = sign-extended instr[31:20].
  - Shifts (funct3 001/101) use alu_b = zero-extended instr[24:20]; instr[30] selects SRA.
  - Shifts with an invalid instr[31:25] → illegal.
- **Opcode 1100011 (branch):**
  - funct3 000 EQ, 001 NE, 100 LTS, 101 GES, 110 LTU, 111 GEU; 010 and 011 → illegal.
  - alu_b = rs2_data.
- **Any other opcode** → illegal.
- alu_a = rs1_data in all legal cases.
- **FSM states:** IDLE, DECODE, EXEC, WB.
  - IDLE → DECODE on instr_valid & instr_ready; instr is latched.
  - DECODE: rs1_addr/rs2_addr are driven from the latched instr; rs data, op and immediate are registered into alu_op/alu_a/alu_b. Legal → EXEC; illegal → IDLE, with illegal pulsed during the first IDLE cycle.
  - EXEC: alu_result and alu_flag are registered into wb_data and br_taken.
    - ALU class → WB.
    - Branch class → IDLE, with br_valid pulsed during the first IDLE cycle.
  - WB: wb_valid = 1; hold until wb_ready, then → IDLE.
- **rd = 0:** WB is skipped (EXEC → IDLE); wb_valid is never asserted.
- alu_op/alu_a/alu_b hold their values from DECODE through the end of EXEC/WB. They return to 0 only on reset.
- wb_addr and wb_data are stable while wb_valid = 1.

## Timing
- **Reset (rst_n low at a rising edge):** state = IDLE and every output = 0, except instr_ready = 1 in the first cycle after reset.
  - Reset overrides any in-flight instruction, including a WB stall; no wb_valid, br_valid or illegal is produced for the aborted instruction.
- instr_ready = (state == IDLE) & ~rst_n-reset-cycle. It is combinational from state and is low in DECODE, EXEC and WB.
- **Latency (handshake at edge N):**
  - DECODE during cycle N+1.
  - EXEC during cycle N+2.
  - wb_valid first high in cycle N+3.
  - br_valid pulse in cycle N+3.
  - illegal pulse in cycle N+2.
- **Back-to-back issue:** instr_ready is high in the cycle where a pulse (br_valid/illegal) is shown, so a new handshake can occur in that same cycle.
  - Best-case throughput: one instruction per 3 cycles (branch, illegal-free ALU with wb_ready = 1 is 4 cycles).
- **WB handshake:**
  - The transfer completes at the edge where wb_valid & wb_ready.
  - wb_valid drops in the following cycle.
  - A wb_ready that is already high when WB is entered completes on the first edge.
- Input instr_valid is ignored outside IDLE.

## Test plan
- **Reset mid-WB:** Reset while wb_valid = 1 and wb_ready = 0 → next cycle all outputs 0, instr_ready = 1, no later wb_valid.
- **SUB write-back:** ADD x3,x1,x2 with funct7 0100000 (SUB), x1 = 5, x2 = 7 → alu_op = 1 in EXEC; wb_valid at N+3 with wb_addr = 3, wb_data = 0xFFFFFFFE. Hold wb_ready = 0 for 4 cycles → data stable, then one transfer.
- **SRAI:** SRAI x5,x4,4 with x4 = 0x80000000 → alu_op = 7, alu_b = 4, wb_data = 0xF8000000.
- **Branch outcomes:** BLTU x1,x2 with x1 = 1, x2 = 0xFFFFFFFF and alu_flag = 1 → br_valid pulse, br_taken = 1 at N+3, no wb_valid. BEQ with unequal operands → br_taken = 0.
- **Illegal instructions:** Opcode 0000011 (load) → illegal pulse at N+2, no wb_valid/br_valid. funct3 010 branch → same.
- **rd = 0 and back-to-back:** ADDI x0,x1,1 → no wb_valid, instr_ready high again at N+3. Back-to-back BEQ instructions accepted at edges N and N+3.
